// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline sequencing controller for the 4-stage core
//   IF/ID (REG1) -> EX (REG2) -> MEM (REG3) -> WB (REG4)
//
// Tracks the destination registers of in-flight instructions in a 3-slot
// scoreboard (EX, MEM, WB).  There is no forwarding path, so it does two things:
//   - On a read-after-write hazard it holds fetch/decode and injects EX bubbles.
//   - After a taken branch it kills the wrong-path REG1 instruction for
//     FLUSH_CYCLES cycles.
// It also keeps saturating debug counters of stall and flush cycles.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   id_valid             REG1 holds a real instruction
//   id_ra_addr/used      source A register and its read enable
//   id_rb_addr/used      source B register and its read enable
//   id_rt_addr/used      rt register (destination or store data) and its read enable
//   id_reg_write         REG1 instruction writes rt
//   ex_branch_taken      branch resolved taken in EX this cycle
//   stall_fetch          hold PC and REG1
//   bubble_ex            zero REG2 write/memory controls
//   flush_id             kill the REG1 instruction
//   hazard_active        registered (stall_fetch | flush_id)
//   stall_count          saturating count of stall cycles
//   flush_count          saturating count of flush cycles
module hazard_ctrl #(
    parameter int WB_BYPASS    = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_ra_addr,
    input  logic             id_ra_used,
    input  logic [4:0]       id_rb_addr,
    input  logic             id_rb_used,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_rt_used,
    input  logic             id_reg_write,
    input  logic             ex_branch_taken,
    output logic             stall_fetch,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             hazard_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Counter load value: FLUSH state covers the cycles after the branch cycle.
    localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_fcnt;
    logic [1:0]       w_fcnt_nxt;

    logic             r_ex_v;
    logic [4:0]       r_ex_a;
    logic             r_mem_v;
    logic [4:0]       r_mem_a;
    logic             r_wb_v;
    logic [4:0]       r_wb_a;

    logic             r_hazard_active;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_wb_chk;
    logic             w_hit_ra;
    logic             w_hit_rb;
    logic             w_hit_rt;
    logic             w_hazard;
    logic             w_ex_new_v;

    function automatic logic src_hit(
        input logic       used,
        input logic [4:0] addr,
        input logic       ex_v,
        input logic [4:0] ex_a,
        input logic       mem_v,
        input logic [4:0] mem_a,
        input logic       wb_v,
        input logic [4:0] wb_a
    );
        return used & ((ex_v  & (ex_a  == addr)) |
                       (mem_v & (mem_a == addr)) |
                       (wb_v  & (wb_a  == addr)));
    endfunction

    // With same-cycle WB write-through the WB slot never causes a hazard.
    assign w_wb_chk = (WB_BYPASS == 0) ? r_wb_v : 1'b0;

    assign w_hit_ra = src_hit(id_ra_used, id_ra_addr, r_ex_v, r_ex_a,
                              r_mem_v, r_mem_a, w_wb_chk, r_wb_a);
    assign w_hit_rb = src_hit(id_rb_used, id_rb_addr, r_ex_v, r_ex_a,
                              r_mem_v, r_mem_a, w_wb_chk, r_wb_a);
    assign w_hit_rt = src_hit(id_rt_used, id_rt_addr, r_ex_v, r_ex_a,
                              r_mem_v, r_mem_a, w_wb_chk, r_wb_a);

    assign w_hazard = id_valid & (w_hit_ra | w_hit_rb | w_hit_rt);

    // Stalled or flushed instructions do not advance, so they never enter EX.
    assign w_ex_new_v = id_valid & id_reg_write & ~stall_fetch & ~flush_id;

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        stall_fetch = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        case (r_state)
            ST_RUN, ST_STALL: begin
                if (ex_branch_taken) begin
                    flush_id    = 1'b1;
                    w_fcnt_nxt  = FC_LOAD;
                    w_state_nxt = (FC_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
                end else if (w_hazard) begin
                    stall_fetch = 1'b1;
                    bubble_ex   = 1'b1;
                    w_state_nxt = ST_STALL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_id = 1'b1;
                if (ex_branch_taken) begin
                    w_fcnt_nxt  = FC_LOAD;
                    w_state_nxt = (FC_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
                end else begin
                    w_fcnt_nxt  = (r_fcnt != 2'd0) ? (r_fcnt - 2'd1) : 2'd0;
                    w_state_nxt = (r_fcnt <= 2'd1) ? ST_RUN : ST_FLUSH;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_fcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ex_v  <= 1'b0;
            r_ex_a  <= '0;
            r_mem_v <= 1'b0;
            r_mem_a <= '0;
            r_wb_v  <= 1'b0;
            r_wb_a  <= '0;
        end else begin
            r_ex_v  <= w_ex_new_v;
            r_ex_a  <= id_rt_addr;
            r_mem_v <= r_ex_v;
            r_mem_a <= r_ex_a;
            r_wb_v  <= r_mem_v;
            r_wb_a  <= r_mem_a;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hazard_active <= 1'b0;
            r_stall_cnt     <= '0;
            r_flush_cnt     <= '0;
        end else begin
            r_hazard_active <= stall_fetch | flush_id;
            if (stall_fetch && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush_id && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign hazard_active = r_hazard_active;
    assign stall_count   = r_stall_cnt;
    assign flush_count   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_ra_addr;
    logic        id_ra_used;
    logic [4:0]  id_rb_addr;
    logic        id_rb_used;
    logic [4:0]  id_rt_addr;
    logic        id_rt_used;
    logic        id_reg_write;
    logic        ex_branch_taken;
    logic        stall_fetch;
    logic        bubble_ex;
    logic        flush_id;
    logic        hazard_active;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int n_checks;
    int n_errors;

    hazard_ctrl #(
        .WB_BYPASS   (1),
        .FLUSH_CYCLES(2),
        .CNT_W       (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_ra_addr     (id_ra_addr),
        .id_ra_used     (id_ra_used),
        .id_rb_addr     (id_rb_addr),
        .id_rb_used     (id_rb_used),
        .id_rt_addr     (id_rt_addr),
        .id_rt_used     (id_rt_used),
        .id_reg_write   (id_reg_write),
        .ex_branch_taken(ex_branch_taken),
        .stall_fetch    (stall_fetch),
        .bubble_ex      (bubble_ex),
        .flush_id       (flush_id),
        .hazard_active  (hazard_active),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one REG1 instruction (all fields) for the current cycle.
    task automatic ins(input logic v,
                       input logic [4:0] ra, input logic rau,
                       input logic [4:0] rb, input logic rbu,
                       input logic [4:0] rt, input logic rtu,
                       input logic rw, input logic br);
        id_valid        = v;
        id_ra_addr      = ra;
        id_ra_used      = rau;
        id_rb_addr      = rb;
        id_rb_used      = rbu;
        id_rt_addr      = rt;
        id_rt_used      = rtu;
        id_reg_write    = rw;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int unsigned n);
        idle();
        for (int unsigned i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        idle();

        // Reset state
        #3;
        check("rst_stall",  {31'd0, stall_fetch},   32'd0);
        check("rst_bubble", {31'd0, bubble_ex},     32'd0);
        check("rst_flush",  {31'd0, flush_id},      32'd0);
        check("rst_hact",   {31'd0, hazard_active}, 32'd0);
        check("rst_scnt",   {16'd0, stall_count},   32'd0);
        check("rst_fcnt",   {16'd0, flush_count},   32'd0);
        @(negedge clock);
        reset = 1'b0;
        next_cycle();

        // EX-slot hazard: write r3, then reader ra=3 (also writes r10)
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        @(negedge clock); check("ex_wr_stall", {31'd0, stall_fetch}, 32'd0);
        next_cycle();
        ins(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check("ex_s1_stall",  {31'd0, stall_fetch}, 32'd1);
        check("ex_s1_bubble", {31'd0, bubble_ex},   32'd1);
        next_cycle();
        @(negedge clock);
        check("ex_s2_stall", {31'd0, stall_fetch},   32'd1);
        check("ex_s2_hact",  {31'd0, hazard_active}, 32'd1);
        next_cycle();
        @(negedge clock);
        check("ex_issue_stall",  {31'd0, stall_fetch}, 32'd0);
        check("ex_issue_bubble", {31'd0, bubble_ex},   32'd0);
        check("ex_issue_hact",   {31'd0, hazard_active}, 32'd1);
        next_cycle();
        // id_valid=0 with a matching source (r10 in EX) must not stall
        ins(1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check("inval_stall", {31'd0, stall_fetch}, 32'd0);
        check("ex_scnt",     {16'd0, stall_count}, 32'd2);
        check("ex_hact_off", {31'd0, hazard_active}, 32'd0);
        drain(4);

        // MEM-slot hazard: write r5, independent op, reader rb=5
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0);
        next_cycle();
        ins(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); check("mem_indep_stall", {31'd0, stall_fetch}, 32'd0);
        next_cycle();
        ins(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); check("mem_s1_stall", {31'd0, stall_fetch}, 32'd1);
        next_cycle();
        @(negedge clock); check("mem_issue_stall", {31'd0, stall_fetch}, 32'd0);
        next_cycle();
        drain(4);
        check("mem_scnt", {16'd0, stall_count}, 32'd3);

        // Store-data dependency: write r7, store reading rt=7
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
        next_cycle();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        @(negedge clock); check("st_s1_stall", {31'd0, stall_fetch}, 32'd1);
        next_cycle();
        @(negedge clock); check("st_s2_stall", {31'd0, stall_fetch}, 32'd1);
        next_cycle();
        @(negedge clock); check("st_issue_stall", {31'd0, stall_fetch}, 32'd0);
        drain(4);
        // Same store with rt not read
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
        next_cycle();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clock); check("st_nouse_stall", {31'd0, stall_fetch}, 32'd0);
        drain(4);
        check("st_scnt", {16'd0, stall_count}, 32'd5);

        // Branch flush (FLUSH_CYCLES=2); flushed r9 writers never reach scoreboard
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        check("br_c0_flush", {31'd0, flush_id},    32'd1);
        check("br_c0_stall", {31'd0, stall_fetch}, 32'd0);
        next_cycle();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
        @(negedge clock); check("br_c1_flush", {31'd0, flush_id}, 32'd1);
        next_cycle();
        ins(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("br_c2_flush",  {31'd0, flush_id},    32'd0);
        check("br_rd9_stall", {31'd0, stall_fetch}, 32'd0);
        check("br_fcnt",      {16'd0, flush_count}, 32'd2);
        drain(4);

        // Branch arriving while stalled
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0);
        next_cycle();
        ins(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); check("bs_s1_stall", {31'd0, stall_fetch}, 32'd1);
        next_cycle();
        ex_branch_taken = 1'b1;
        @(negedge clock);
        check("bs_br_flush",  {31'd0, flush_id},    32'd1);
        check("bs_br_stall",  {31'd0, stall_fetch}, 32'd0);
        check("bs_br_bubble", {31'd0, bubble_ex},   32'd0);
        next_cycle();
        ex_branch_taken = 1'b0;
        @(negedge clock);
        check("bs_fl_flush", {31'd0, flush_id},    32'd1);
        check("bs_fl_stall", {31'd0, stall_fetch}, 32'd0);
        next_cycle();
        idle();
        @(negedge clock);
        check("bs_end_flush", {31'd0, flush_id},    32'd0);
        check("bs_fcnt",      {16'd0, flush_count}, 32'd4);
        check("bs_scnt",      {16'd0, stall_count}, 32'd6);
        drain(4);

        // Reset during the second stall cycle
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0);
        next_cycle();
        ins(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); check("rs_s1_stall", {31'd0, stall_fetch}, 32'd1);
        next_cycle();
        @(negedge clock); check("rs_s2_stall", {31'd0, stall_fetch}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rs_stall",  {31'd0, stall_fetch},   32'd0);
        check("rs_bubble", {31'd0, bubble_ex},     32'd0);
        check("rs_flush",  {31'd0, flush_id},      32'd0);
        check("rs_hact",   {31'd0, hazard_active}, 32'd0);
        check("rs_scnt",   {16'd0, stall_count},   32'd0);
        check("rs_fcnt",   {16'd0, flush_count},   32'd0);
        #1;
        reset = 1'b0;
        next_cycle();
        @(negedge clock);
        check("rs_issue_stall", {31'd0, stall_fetch},   32'd0);
        check("rs_issue_hact",  {31'd0, hazard_active}, 32'd0);
        check("rs_issue_scnt",  {16'd0, stall_count},   32'd0);
        drain(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
